// File: rtl/reaction_player.sv
// rtl/reaction_player.sv - automated player for a reaction-time game: waits for the LED, presses after a set delay, grades the result
module reaction_player #(
    parameter int CNT_W     = 16,
    parameter int PRESS_LEN = 4,
    parameter int TIMEOUT   = 1000,
    parameter int TOL       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             arm,
    input  logic [CNT_W-1:0] delay_cfg,
    input  logic             led_in,
    output logic             btn_out,
    input  logic [CNT_W-1:0] result_in,
    input  logic             result_valid_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] measured
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);
    localparam logic [7:0]       PRESS_C   = 8'(PRESS_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LED,
        DELAY,
        PRESS,
        WAIT_RESULT,
        REPORT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] dly_q;
    logic [CNT_W-1:0] dcnt;
    logic [7:0]       pcnt;
    logic [CNT_W-1:0] to_cnt;
    logic             to_q;
    logic             led_prev;

    logic             led_rise;
    logic [CNT_W:0]   diff;
    logic             res_ok;
    logic [CNT_W-1:0] to_nxt;
    logic             to_hit;

    // Edge detect, one-extra-bit absolute difference for grading, and timeout compare
    always_comb begin
        led_rise = led_in & ~led_prev;
        diff     = '0;
        if (result_in >= dly_q) begin
            diff = {1'b0, result_in} - {1'b0, dly_q};
        end else begin
            diff = {1'b0, dly_q} - {1'b0, result_in};
        end
        res_ok = (diff <= TOL_C);
        to_nxt = to_cnt + 1'b1;
        to_hit = (to_nxt == TIMEOUT_C);
    end

    // Trial sequencer; every output is a register so it drops straight away on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dly_q    <= '0;
            dcnt     <= '0;
            pcnt     <= '0;
            to_cnt   <= '0;
            to_q     <= 1'b0;
            led_prev <= 1'b0;
            btn_out  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            measured <= '0;
        end else if (ena) begin
            led_prev <= led_in;
            case (state)
                IDLE: begin
                    if (arm) begin
                        dly_q  <= delay_cfg;
                        to_cnt <= '0;
                        to_q   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= WAIT_LED;
                    end
                end
                WAIT_LED: begin
                    // An edge wins over an expiring timeout on the same cycle
                    if (led_rise) begin
                        dcnt  <= dly_q;
                        state <= DELAY;
                    end else if (to_hit) begin
                        to_q    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        done    <= 1'b1;
                        state   <= REPORT;
                    end else begin
                        to_cnt <= to_nxt;
                    end
                end
                DELAY: begin
                    if (dcnt == '0) begin
                        btn_out <= 1'b1;
                        pcnt    <= PRESS_C;
                        state   <= PRESS;
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                PRESS: begin
                    if (pcnt == 8'd0) begin
                        btn_out <= 1'b0;
                        to_cnt  <= '0;
                        state   <= WAIT_RESULT;
                    end else begin
                        pcnt <= pcnt - 1'b1;
                    end
                end
                WAIT_RESULT: begin
                    // A valid result wins over an expiring timeout on the same cycle
                    if (result_valid_in) begin
                        measured <= result_in;
                        pass     <= res_ok & ~to_q;
                        timeout  <= 1'b0;
                        done     <= 1'b1;
                        state    <= REPORT;
                    end else if (to_hit) begin
                        to_q    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        done    <= 1'b1;
                        state   <= REPORT;
                    end else begin
                        to_cnt <= to_nxt;
                    end
                end
                REPORT: begin
                    done    <= 1'b0;
                    pass    <= 1'b0;
                    timeout <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_player.sv
// tb/tb_reaction_player.sv - scoreboard bench for reaction_player
module tb_reaction_player;

    localparam int CNT_W     = 16;
    localparam int PRESS_LEN = 4;
    localparam int TIMEOUT   = 20;
    localparam int TOL       = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             arm;
    logic [CNT_W-1:0] delay_cfg;
    logic             led_in;
    logic             btn_out;
    logic [CNT_W-1:0] result_in;
    logic             result_valid_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] measured;

    reaction_player #(
        .CNT_W    (CNT_W),
        .PRESS_LEN(PRESS_LEN),
        .TIMEOUT  (TIMEOUT),
        .TOL      (TOL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .arm            (arm),
        .delay_cfg      (delay_cfg),
        .led_in         (led_in),
        .btn_out        (btn_out),
        .result_in      (result_in),
        .result_valid_in(result_valid_in),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .measured       (measured)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               rise;
        int               width;
        logic             pass;
        logic             to;
        logic [CNT_W-1:0] meas;
        int               done_cyc;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_it;
    int               cyc = 0;
    int               n_checks = 0;
    int               n_errs = 0;
    int               rise_cyc = -1;
    int               hi_cnt = 0;
    logic             btn_prev = 1'b0;
    bit               done_prev_chk = 1'b0;
    logic [CNT_W-1:0] last_meas = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: track the press, pop and compare on every done pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            rise_cyc      = -1;
            hi_cnt        = 0;
            btn_prev      = 1'b0;
            done_prev_chk = 1'b0;
        end else begin
            if (done_prev_chk) begin
                check_val("done_one_cycle", done, 0);
                check_val("pass_idle", pass, 0);
                check_val("timeout_idle", timeout, 0);
                done_prev_chk = 1'b0;
            end
            if (btn_out && !btn_prev) rise_cyc = cyc;
            if (btn_out) hi_cnt++;
            btn_prev = btn_out;
            if (done) begin
                check_val("unexpected_done", (sb.size() == 0), 0);
                if (sb.size() != 0) begin
                    mon_it = sb.pop_front();
                    check_val("btn_rise", rise_cyc, mon_it.rise);
                    check_val("btn_width", hi_cnt, mon_it.width);
                    check_val("pass", pass, mon_it.pass);
                    check_val("timeout", timeout, mon_it.to);
                    check_val("measured", measured, mon_it.meas);
                    check_val("done_cycle", cyc, mon_it.done_cyc);
                end
                rise_cyc      = -1;
                hi_cnt        = 0;
                done_prev_chk = 1'b1;
            end
        end
    end

    task automatic wait_btn(input logic lvl, input int budget);
        int n = 0;
        while (btn_out !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(lvl ? "wait_btn_high" : "wait_btn_low", btn_out, lvl);
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", sb.size(), 0);
    endtask

    task automatic finish_trial(input int n_led, input int dly, input logic [CNT_W-1:0] res, input int stall);
        exp_t it;
        int d;
        wait_btn(1'b1, dly + stall + 10);
        led_in = 1'b0;
        wait_btn(1'b0, PRESS_LEN + 5);
        d = int'(res) - dly;
        if (d < 0) d = -d;
        it.rise     = n_led + dly + 2 + stall;
        it.width    = PRESS_LEN;
        it.pass     = (d <= TOL);
        it.to       = 1'b0;
        it.meas     = res;
        it.done_cyc = cyc + 1;
        sb.push_back(it);
        last_meas       = res;
        result_in       = res;
        result_valid_in = 1'b1;
        @(negedge clk);
        result_valid_in = 1'b0;
        wait_empty(10);
    endtask

    task automatic run_trial(input int dly, input logic [CNT_W-1:0] res, input int pre);
        int n_led;
        @(negedge clk);
        delay_cfg = CNT_W'(dly);
        arm       = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        repeat (pre) @(negedge clk);
        led_in = 1'b1;
        n_led  = cyc;
        finish_trial(n_led, dly, res, 0);
    endtask

    task automatic run_timeout(input logic led_with_arm);
        exp_t it;
        @(negedge clk);
        delay_cfg   = 16'd3;
        arm         = 1'b1;
        led_in      = led_with_arm;
        it.rise     = -1;
        it.width    = 0;
        it.pass     = 1'b0;
        it.to       = 1'b1;
        it.meas     = last_meas;
        it.done_cyc = cyc + 1 + TIMEOUT;
        sb.push_back(it);
        @(negedge clk);
        arm = 1'b0;
        wait_empty(TIMEOUT + 10);
        led_in = 1'b0;
        @(negedge clk);
    endtask

    int t_dly[5] = '{5, 0, 1, 4, 7};
    int t_res[5] = '{6, 9, 3, 2, 10};
    int t_pre[5] = '{2, 1, 0, 3, 0};

    initial begin
        int n_led;
        rst_n = 1'b0; ena = 1'b1; arm = 1'b0; delay_cfg = '0;
        led_in = 1'b0; result_in = '0; result_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_btn", btn_out, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_pass", pass, 0);
        check_val("rst_timeout", timeout, 0);
        check_val("rst_measured", measured, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_trial(t_dly[i], CNT_W'(t_res[i]), t_pre[i]);

        run_timeout(1'b0);
        run_timeout(1'b1);

        // Second arm, LED fall and a 3-cycle enable stall, all inside DELAY
        @(negedge clk);
        delay_cfg = 16'd10;
        arm       = 1'b1;
        @(negedge clk);
        arm    = 1'b0;
        led_in = 1'b1;
        n_led  = cyc;
        repeat (2) @(negedge clk);
        delay_cfg = 16'd3;
        arm       = 1'b1;
        led_in    = 1'b0;
        @(negedge clk);
        arm = 1'b0;
        ena = 1'b0;
        repeat (3) @(negedge clk);
        check_val("busy_stall", busy, 1);
        ena = 1'b1;
        finish_trial(n_led, 10, 16'd10, 3);

        // Reset in the middle of a press
        @(negedge clk);
        delay_cfg = 16'd3;
        arm       = 1'b1;
        @(negedge clk);
        arm    = 1'b0;
        led_in = 1'b1;
        wait_btn(1'b1, 20);
        led_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_btn", btn_out, 0);
        check_val("async_rst_busy", busy, 0);
        check_val("async_rst_measured", measured, 0);
        last_meas = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        delay_cfg = 16'd2;
        arm       = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check_val("arm_after_rst", busy, 1);
        led_in = 1'b1;
        n_led  = cyc;
        finish_trial(n_led, 2, 16'd1, 0);

        // Widest delay against a zero result
        run_trial(65535, 16'd0, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
